// File: rtl/rng_sequence_loader_pkg.sv
// rng_sequence_loader_pkg: FSM encoding and address map shared by the sequence loader.
package rng_sequence_loader_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RNG = 3'd1,
    GAP      = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4
  } state_e;
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0400;
  localparam logic [15:0] RNG_SEED_ADDR     = 16'h07FE;
endpackage

// File: rtl/rng_sequence_loader.sv
// rng_sequence_loader: once the LFSR generator releases the bus, stores a clamped-length
// sequence of spaced 4-bit random samples into consecutive memory words.
module rng_sequence_loader
  import rng_sequence_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          MAX_LEN    = 64,
  parameter int          SAMPLE_GAP = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        start,
  input  logic [7:0]  seq_len,
  input  logic        rng_busy,
  input  logic [15:0] rng_value,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_data_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  words_written
);
  localparam logic [7:0] MAX_LEN_8 = 8'(MAX_LEN);
  localparam logic [7:0] GAP_LOAD  = 8'(SAMPLE_GAP - 1);
  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d, idx_q, idx_d, gap_q, gap_d, words_q, words_d;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic        wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic        last;
  logic        unused_rng;
  assign unused_rng    = ^rng_value[15:4];
  assign last          = idx_q == len_q - 8'd1;
  assign mem_address   = addr_q;
  assign mem_wr_en     = wr_q;
  assign mem_data_in   = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = words_q;
  always_ff @(posedge clock) state_q <= !nreset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = !start ? IDLE : (seq_len == 8'd0 ? DONE : WAIT_RNG);
      WAIT_RNG: state_d = rng_busy ? WAIT_RNG : GAP;
      GAP:      state_d = rng_busy ? WAIT_RNG : (gap_q == 8'd0 ? WRITE : GAP);
      WRITE:    state_d = last ? DONE : GAP;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    len_d   = len_q;
    idx_d   = idx_q;
    words_d = words_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    wr_d    = 1'b0;
    done_d  = state_d == DONE;
    case (state_q)
      IDLE: if (start) begin
        len_d   = seq_len > MAX_LEN_8 ? MAX_LEN_8 : seq_len;
        idx_d   = 8'd0;
        words_d = 8'd0;
        busy_d  = 1'b1;
      end
      WAIT_RNG: gap_d = GAP_LOAD;
      GAP: if (!rng_busy) begin
        gap_d  = gap_q == 8'd0 ? gap_q : gap_q - 8'd1;
        addr_d = gap_q == 8'd0 ? BASE_ADDR + {8'd0, idx_q} : addr_q;
        data_d = gap_q == 8'd0 ? {12'd0, rng_value[3:0]} : data_q;
        wr_d   = gap_q == 8'd0;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        words_d = words_q + 8'd1;
        gap_d   = GAP_LOAD;
      end
      DONE: busy_d = 1'b0;
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!nreset) begin
      len_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_rng_sequence_loader.sv
// tb_rng_sequence_loader: directed scenarios with a write scoreboard for rng_sequence_loader.
module tb_rng_sequence_loader;
  logic        clock = 1'b0;
  logic        nreset, start, rng_busy, mem_wr_en, busy, done;
  logic [7:0]  seq_len, words_written;
  logic [15:0] rng_value, mem_address, mem_data_in;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          t;
  typedef struct {
    int          c;
    logic [15:0] a;
    logic [15:0] d;
    logic        b;
  } wr_t;
  wr_t exp_q[$];
  wr_t obs_q[$];

  rng_sequence_loader dut (
    .clock(clock), .nreset(nreset), .start(start), .seq_len(seq_len),
    .rng_busy(rng_busy), .rng_value(rng_value), .mem_address(mem_address),
    .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in), .busy(busy),
    .done(done), .words_written(words_written)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (mem_wr_en) obs_q.push_back('{cyc, mem_address, mem_data_in, rng_busy});

  function automatic logic [15:0] rng_at(int c);
    return 16'(c * 16'h9E37 + 16'h3C1D);
  endfunction

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1 rng_value = rng_at(cyc);
  endtask

  task automatic tick_to(int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(logic [7:0] len);
    t = cyc;
    start = 1'b1;
    seq_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_wr(int c, int k);
    exp_q.push_back('{c, 16'(16'h0400 + k), rng_at(c - 1) & 16'h000F, 1'b0});
  endtask

  task automatic flush(string tag);
    wr_t e, o;
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_cyc"}, o.c, e.c);
      chk({tag, "_addr"}, o.a, e.a);
      chk({tag, "_data"}, o.d, e.d);
      chk({tag, "_rngbusy"}, {31'd0, o.b}, {31'd0, e.b});
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; seq_len = 8'd0; rng_busy = 1'b0; rng_value = rng_at(0);
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr", {16'd0, mem_address}, 32'd0);
    chk("rst_data", {16'd0, mem_data_in}, 32'd0);
    chk("rst_words", {24'd0, words_written}, 32'd0);
    nreset = 1'b1;
    tick(); tick();
    // normal run of three words
    go(8'd3);
    for (int k = 0; k < 3; k++) expect_wr(t + 6 + 5 * k, k);
    chk("n_busy", {31'd0, busy}, 32'd1);
    tick_to(t + 16);
    chk("n_done_early", {31'd0, done}, 32'd0);
    tick_to(t + 17);
    chk("n_done", {31'd0, done}, 32'd1);
    chk("n_words", {24'd0, words_written}, 32'd3);
    tick_to(t + 18);
    chk("n_done_pulse", {31'd0, done}, 32'd0);
    chk("n_busy_end", {31'd0, busy}, 32'd0);
    chk("n_addr_hold", {16'd0, mem_address}, 32'h0402);
    flush("normal");
    // generator still seeding
    rng_busy = 1'b1;
    go(8'd1);
    tick_to(t + 10);
    rng_busy = 1'b0;
    expect_wr(t + 15, 0);
    tick_to(t + 16);
    chk("w_done", {31'd0, done}, 32'd1);
    chk("w_words", {24'd0, words_written}, 32'd1);
    tick();
    flush("wait");
    // generator busy for three cycles in the gap before word 2
    go(8'd4);
    tick_to(t + 13);
    rng_busy = 1'b1;
    tick_to(t + 16);
    rng_busy = 1'b0;
    expect_wr(t + 6, 0);
    expect_wr(t + 11, 1);
    expect_wr(t + 21, 2);
    expect_wr(t + 26, 3);
    tick_to(t + 27);
    chk("m_done", {31'd0, done}, 32'd1);
    chk("m_words", {24'd0, words_written}, 32'd4);
    tick();
    flush("midbusy");
    // zero length
    go(8'd0);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_words", {24'd0, words_written}, 32'd0);
    tick(); tick();
    chk("z_idle", {31'd0, busy}, 32'd0);
    flush("zero");
    // clamp to 64 words
    go(8'd200);
    for (int k = 0; k < 64; k++) expect_wr(t + 6 + 5 * k, k);
    tick_to(t + 322);
    chk("c_done", {31'd0, done}, 32'd1);
    chk("c_words", {24'd0, words_written}, 32'd64);
    chk("c_last_addr", {16'd0, mem_address}, 32'h043F);
    tick_to(t + 330);
    flush("clamp");
    // start while busy is ignored
    go(8'd2);
    tick_to(t + 8);
    start = 1'b1;
    seq_len = 8'd9;
    tick();
    start = 1'b0;
    expect_wr(t + 6, 0);
    expect_wr(t + 11, 1);
    tick_to(t + 12);
    chk("s_done", {31'd0, done}, 32'd1);
    chk("s_words", {24'd0, words_written}, 32'd2);
    tick_to(t + 40);
    chk("s_idle", {31'd0, busy}, 32'd0);
    flush("restart");
    // reset during the third gap
    go(8'd5);
    expect_wr(t + 6, 0);
    expect_wr(t + 11, 1);
    tick_to(t + 13);
    nreset = 1'b0;
    tick();
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_wr", {31'd0, mem_wr_en}, 32'd0);
    chk("r_words", {24'd0, words_written}, 32'd0);
    chk("r_addr", {16'd0, mem_address}, 32'd0);
    nreset = 1'b1;
    tick_to(t + 30);
    flush("reset");
    go(8'd1);
    expect_wr(t + 6, 0);
    tick_to(t + 7);
    chk("r2_done", {31'd0, done}, 32'd1);
    chk("r2_words", {24'd0, words_written}, 32'd1);
    tick();
    flush("after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
